// File: rtl/ctrl_pipe.sv
// Control-bundle pipeline of STAGES stages with per-stage stall/flush and a
// multi-cycle mul/div occupancy tracker that holds stage 0 while busy.
module ctrl_pipe #(
  parameter int W      = 10,
  parameter int STAGES = 3,
  parameter int MD_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          ctrlD,
  input  logic                  validD,
  input  logic                  mdD,
  input  logic                  stallD,
  input  logic [STAGES-1:0]     stall,
  input  logic [STAGES-1:0]     flush,
  output logic [STAGES*W-1:0]   ctrl_q,
  output logic [STAGES-1:0]     valid_q,
  output logic                  md_stall,
  output logic                  md_done
);

  localparam int CW = $clog2(MD_LAT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdState_t;

  mdState_t        state, stateN;
  logic [CW-1:0]   cnt, cntN;

  logic [W-1:0]      ctrlR   [STAGES];
  logic [STAGES-1:0] validR, mdR;

  logic [W-1:0]      upCtrl  [STAGES];
  logic [STAGES-1:0] upValid, upMd, effStall, upStalled;
  logic              load0, mdStart;

  // Upstream view of every stage; stage 0 sees decode, others the previous stage.
  always_comb begin
    upCtrl[0]    = ctrlD;
    upValid[0]   = validD;
    upMd[0]      = mdD;
    effStall[0]  = stall[0] | md_stall;
    upStalled[0] = stallD;
    for (int unsigned i = 1; i < STAGES; i++) begin
      upCtrl[i]    = ctrlR[i-1];
      upValid[i]   = validR[i-1];
      upMd[i]      = mdR[i-1];
      effStall[i]  = stall[i];
      upStalled[i] = effStall[i-1];
    end
  end

  assign load0   = !flush[0] && !effStall[0] && !stallD;
  assign mdStart = load0 && validD && mdD;

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < STAGES; i++) begin
      if (rst || flush[i]) begin
        ctrlR[i]  <= '0;
        validR[i] <= 1'b0;
        mdR[i]    <= 1'b0;
      end else if (!effStall[i]) begin
        if (upStalled[i]) begin
          ctrlR[i]  <= '0;
          validR[i] <= 1'b0;
          mdR[i]    <= 1'b0;
        end else begin
          ctrlR[i]  <= upCtrl[i];
          validR[i] <= upValid[i];
          mdR[i]    <= upMd[i];
        end
      end
    end
  end

  always_comb begin
    ctrl_q = '0;
    for (int unsigned i = 0; i < STAGES; i++) begin
      ctrl_q[i*W +: W] = ctrlR[i];
    end
  end

  assign valid_q = validR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= stateN;
      cnt   <= cntN;
    end
  end

  // DONE can hand straight over to a new BUSY because md_stall is low there.
  always_comb begin
    stateN = state;
    cntN   = cnt;
    case (state)
      IDLE: begin
        if (mdStart) begin
          stateN = BUSY;
          cntN   = CW'(MD_LAT - 1);
        end
      end
      BUSY: begin
        if (flush[0]) begin
          stateN = IDLE;
          cntN   = '0;
        end else if (cnt == CW'(1)) begin
          stateN = DONE;
          cntN   = '0;
        end else begin
          cntN   = cnt - CW'(1);
        end
      end
      DONE: begin
        if (mdStart) begin
          stateN = BUSY;
          cntN   = CW'(MD_LAT - 1);
        end else begin
          stateN = IDLE;
          cntN   = '0;
        end
      end
      default: begin
        stateN = IDLE;
        cntN   = '0;
      end
    endcase
  end

  always_comb begin
    md_stall = (state == BUSY);
    md_done  = (state == DONE);
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed and randomized checks of ctrl_pipe against an occupancy-count
// reference model of the pipeline and the mul/div unit.
module tb_ctrl_pipe;

  localparam int W = 10;
  localparam int S = 3;
  localparam int L = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [W-1:0]     ctrlD;
  logic             validD, mdD, stallD;
  logic [S-1:0]     stall, flush;
  logic [S*W-1:0]   ctrl_q;
  logic [S-1:0]     valid_q;
  logic             md_stall, md_done;

  ctrl_pipe #(.W(W), .STAGES(S), .MD_LAT(L)) dut (
    .clk(clk), .rst(rst), .ctrlD(ctrlD), .validD(validD), .mdD(mdD),
    .stallD(stallD), .stall(stall), .flush(flush), .ctrl_q(ctrl_q),
    .valid_q(valid_q), .md_stall(md_stall), .md_done(md_done)
  );

  always #5 clk = ~clk;

  int testCnt = 0;
  int failCnt = 0;
  string phase = "init";

  // Reference: per-stage contents plus remaining mul/div occupancy cycles.
  logic [W-1:0] mCtrl [S];
  logic         mValid [S];
  int           mdLeft = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testCnt++;
    assert (got === exp) else begin
      failCnt++;
      $error("FAIL %s/%s got %0h exp %0h", phase, tag, got, exp);
    end
  endtask

  task automatic modelStep(input logic [W-1:0] c, input logic v, m, sd,
                           input logic [S-1:0] st, fl, input logic r);
    logic [S-1:0] es, us;
    int nl;
    es[0] = st[0] | (mdLeft > 1);
    us[0] = sd;
    for (int i = 1; i < S; i++) begin
      es[i] = st[i];
      us[i] = es[i-1];
    end
    if (r || fl[0]) nl = 0;
    else begin
      nl = (mdLeft > 0) ? mdLeft - 1 : 0;
      if (!es[0] && !sd && v && m) nl = L;
    end
    mdLeft = nl;
    for (int i = S - 1; i >= 0; i--) begin
      if (r || fl[i]) begin
        mCtrl[i] = '0; mValid[i] = 1'b0;
      end else if (!es[i]) begin
        if (us[i]) begin
          mCtrl[i] = '0; mValid[i] = 1'b0;
        end else if (i == 0) begin
          mCtrl[i] = c; mValid[i] = v;
        end else begin
          mCtrl[i] = mCtrl[i-1]; mValid[i] = mValid[i-1];
        end
      end
    end
  endtask

  task automatic cycle(input logic [W-1:0] c, input logic v, m, sd,
                       input logic [S-1:0] st, fl, input logic r);
    logic [S*W-1:0] expC;
    logic [S-1:0]   expV;
    ctrlD = c; validD = v; mdD = m; stallD = sd; stall = st; flush = fl; rst = r;
    modelStep(c, v, m, sd, st, fl, r);
    @(posedge clk);
    #1;
    expC = '0;
    for (int i = 0; i < S; i++) begin
      expC[i*W +: W] = mCtrl[i];
      expV[i]        = mValid[i];
    end
    chk("ctrl_q",   64'(ctrl_q),   64'(expC));
    chk("valid_q",  64'(valid_q),  64'(expV));
    chk("md_stall", 64'(md_stall), 64'(mdLeft > 1));
    chk("md_done",  64'(md_done),  64'(mdLeft == 1));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle('0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int pend, nDone, doneAt0, doneAt1, doneSeen;
    logic sd, v;
    logic [W-1:0] c;

    for (int i = 0; i < S; i++) begin
      mCtrl[i] = '0; mValid[i] = 1'b0;
    end
    ctrlD = '0; validD = 0; mdD = 0; stallD = 0; stall = '0; flush = '0; rst = 1;

    phase = "reset";
    cycle('0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b1);
    cycle(10'h3FF, 1'b1, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("rst_valid", 64'(valid_q), 64'(0));

    phase = "flow";
    cycle(10'h2A5, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("e1_valid", 64'(valid_q), 64'(3'b001));
    chk("e1_ctrl0", 64'(ctrl_q[W-1:0]), 64'(10'h2A5));
    idle(1);
    chk("e2_valid", 64'(valid_q), 64'(3'b010));
    chk("e2_ctrl1", 64'(ctrl_q[2*W-1:W]), 64'(10'h2A5));
    idle(1);
    chk("e3_valid", 64'(valid_q), 64'(3'b100));
    chk("e3_ctrl2", 64'(ctrl_q[3*W-1:2*W]), 64'(10'h2A5));

    phase = "stall";
    cycle(10'h155, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    cycle(10'h0AA, 1'b1, 1'b0, 1'b0, 3'b001, '0, 1'b0);
    chk("hold0", 64'(ctrl_q[W-1:0]), 64'(10'h155));
    chk("bubble1", 64'({ctrl_q[2*W-1:W], valid_q[1]}), 64'(0));
    cycle(10'h0AA, 1'b1, 1'b0, 1'b0, 3'b001, '0, 1'b0);
    chk("hold0b", 64'(ctrl_q[W-1:0]), 64'(10'h155));
    idle(3);

    phase = "muldiv";
    cycle(10'h1C3, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    chk("busy", 64'(md_stall), 64'(1));
    idle(2);
    chk("busy3", 64'(md_stall), 64'(1));
    idle(1);
    chk("done", 64'(md_done), 64'(1));
    idle(1);
    chk("md_to_m", 64'(ctrl_q[2*W-1:W]), 64'(10'h1C3));
    idle(2);

    phase = "flushbusy";
    cycle(10'h0F0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    idle(1);
    cycle('0, 1'b0, 1'b0, 1'b0, '0, 3'b001, 1'b0);
    chk("fl_stall", 64'(md_stall), 64'(0));
    chk("fl_v0", 64'(valid_q[0]), 64'(0));
    doneSeen = 0;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      if (md_done) doneSeen++;
    end
    chk("fl_nodone", 64'(doneSeen), 64'(0));

    phase = "prio";
    cycle(10'h111, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0);
    idle(1);
    cycle('0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b010, 1'b0);
    chk("fl_st1", 64'({ctrl_q[2*W-1:W], valid_q[1]}), 64'(0));
    cycle(10'h222, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0);
    idle(1);
    cycle('0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("rst_all", 64'({ctrl_q, valid_q, md_stall, md_done}), 64'(0));
    doneSeen = 0;
    for (int k = 0; k < 4; k++) begin
      idle(1);
      if (md_done) doneSeen++;
    end
    chk("rst_nodone", 64'(doneSeen), 64'(0));

    phase = "b2b";
    pend = 2; nDone = 0; doneAt0 = -1; doneAt1 = -1;
    for (int k = 0; k < 14; k++) begin
      sd = (mdLeft > 1);
      v  = (pend > 0);
      c  = (pend == 2) ? 10'h3C1 : 10'h0F2;
      cycle(c, v, v, sd, '0, '0, 1'b0);
      if (v && !sd) pend--;
      if (md_done) begin
        if (nDone == 0) doneAt0 = k; else doneAt1 = k;
        nDone++;
      end
    end
    chk("b2b_pulses", 64'(nDone), 64'(2));
    chk("b2b_gap", 64'(doneAt1 - doneAt0), 64'(L));

    phase = "random";
    for (int k = 0; k < 400; k++) begin
      logic [S-1:0] st, fl;
      for (int i = 0; i < S; i++) begin
        st[i] = ($urandom_range(0, 5) == 0);
        fl[i] = ($urandom_range(0, 7) == 0);
      end
      cycle(W'($urandom_range(0, 1023)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            st, fl, ($urandom_range(0, 63) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe.md
CTRL_PIPE -- requirements
Module: ctrl_pipe

Interface
REQ-001 The block SHALL expose parameter W, default 10, as the width of one control bundle.
REQ-002 The block SHALL expose parameter STAGES, default 3, legal range 2..8, as the number of pipeline stages (stage 0 = E, 1 = M, 2 = W, ...).
REQ-003 The block SHALL expose parameter MD_LAT, default 4, legal range 2..63, as the multiply/divide occupancy of stage 0 in cycles.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The block SHALL have port ctrlD, input, W bits: the decoded control bundle.
REQ-007 The block SHALL have port validD, input, 1 bit: ctrlD holds a real instruction.
REQ-008 The block SHALL have port mdD, input, 1 bit: the instruction is a multi-cycle mul/div.
REQ-009 The block SHALL have port stallD, input, 1 bit: the decode stage is stalled.
REQ-010 The block SHALL have port stall, input, STAGES bits: per-stage hold request.
REQ-011 The block SHALL have port flush, input, STAGES bits: per-stage kill request.
REQ-012 The block SHALL have port ctrl_q, output, STAGES*W bits: stage i bundle at bits [i*W +: W].
REQ-013 The block SHALL have port valid_q, output, STAGES bits: per-stage valid.
REQ-014 The block SHALL have port md_stall, output, 1 bit: mul/div busy; upstream stages must hold.
REQ-015 The block SHALL have port md_done, output, 1 bit: one-cycle pulse in the final mul/div cycle.

Function
REQ-016 Stage i (ctrl, valid, md) SHALL update each edge by priority: rst, then flush[i] (all zero), then effective stall (hold), then upstream-stalled (bubble: all zero), else load from upstream.
REQ-017 The upstream of stage 0 SHALL be {ctrlD, validD, mdD}; the upstream of stage i>0 SHALL be stage i-1.
REQ-018 Effective stall SHALL be stall[0] | md_stall for stage 0 and stall[i] for i>0.
REQ-019 Upstream-stalled SHALL be stallD for stage 0 and the effective stall of stage i-1 for i>0.
REQ-020 A bubble or flushed stage SHALL present ctrl = 0 and valid = 0; a stage with valid = 0 SHALL never start mul/div.
REQ-021 Latency SHALL be one cycle per stage: an unstalled bundle at ctrlD appears at stage i after i+1 edges.
REQ-022 The mul/div FSM SHALL have states IDLE, BUSY and DONE, and a counter of ceil(log2(MD_LAT)) bits.
REQ-023 When stage 0 loads an entry with validD & mdD (from IDLE or DONE), the FSM SHALL enter BUSY with cnt = MD_LAT-1.
REQ-024 In BUSY, if cnt == 1 the FSM SHALL go to DONE with cnt = 0; otherwise cnt SHALL decrement.
REQ-025 DONE SHALL last one cycle, then the FSM SHALL go to IDLE unless a new mul/div loads into stage 0 at that edge.
REQ-026 md_stall SHALL be 1 exactly in BUSY, and md_done SHALL be 1 exactly in DONE, so stage 0 is occupied for MD_LAT cycles.
REQ-027 flush[0] in BUSY or DONE SHALL force IDLE and cnt = 0 at that edge, with no md_done pulse.
REQ-028 stall[0] asserted in DONE SHALL hold stage 0 without restarting the FSM; the FSM SHALL go to IDLE after DONE regardless.
REQ-029 Simultaneous flush[i] and stall[i] SHALL resolve as flush.

Reset
REQ-030 At an edge with rst = 1, all ctrl_q, valid_q and stage md bits SHALL be 0, the FSM SHALL be IDLE, cnt = 0, md_stall = 0 and md_done = 0.
REQ-031 rst mid-BUSY SHALL abort the operation with no md_done pulse.

Verification
REQ-032 Straight flow: STAGES=3, ctrlD=0x2A5 with validD=1 and all stalls 0 -> 0x2A5 appears at stage 0, 1 and 2 on edges 1, 2 and 3, with valid_q=001, 010, 100.
REQ-033 Stall bubble: stall[0]=1 for 2 cycles with stage 0 = 0x155 -> stage 0 holds 0x155; stage 1 gets ctrl=0 and valid=0 for 2 cycles.
REQ-034 Mul/div: MD_LAT=4, mdD=1 loaded -> md_stall=1 for 3 cycles, then md_done=1 for 1 cycle; stage 1 receives the bundle on the edge after DONE.
REQ-035 Flush during BUSY: flush[0] at cnt=2 -> next cycle FSM is IDLE, md_stall=0, valid_q[0]=0, and md_done never pulses.
REQ-036 Priority: flush[1]=1 and stall[1]=1 in the same cycle -> stage 1 is zeroed; also rst=1 in the middle of BUSY -> all outputs 0 on the next cycle.
REQ-037 Back-to-back: two mul/div bundles fed consecutively -> the second waits in decode (stallD driven by md_stall) and BUSY re-enters straight from DONE, giving two md_done pulses MD_LAT cycles apart.
